// File: rtl/alu_operand_collector.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : alu_operand_collector
// Description : Gathers the operands of one ALU operation over up to TIMEOUT
//               cycles and presents the complete, aligned operation to the ALU
//               core as a single-cycle out_valid pulse. Raises timeout_err if
//               the arrival window closes before the needed operands arrive.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_operand_collector #(
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic             mode,
    input  logic [3:0]       cmd,
    input  logic             cin,
    input  logic [1:0]       inp_valid,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    output logic             out_valid,
    output logic             out_mode,
    output logic [3:0]       out_cmd,
    output logic             out_cin,
    output logic [WIDTH-1:0] out_opa,
    output logic [WIDTH-1:0] out_opb,
    output logic             timeout_err,
    output logic             busy
);

    localparam int                 c_CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(TIMEOUT - 1);
    localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);

    localparam logic [0:0] c_IDLE = 1'b0;
    localparam logic [0:0] c_WAIT = 1'b1;

    logic [0:0]         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [1:0]         r_coll;
    logic [1:0]         r_need;
    logic               r_mode;
    logic [3:0]         r_cmd;
    logic               r_cin;
    logic [WIDTH-1:0]   r_opa;
    logic [WIDTH-1:0]   r_opb;
    logic               r_out_valid;
    logic               r_timeout;
    logic               r_out_mode;
    logic [3:0]         r_out_cmd;
    logic               r_out_cin;
    logic [WIDTH-1:0]   r_out_opa;
    logic [WIDTH-1:0]   r_out_opb;

    logic [1:0]         w_need_dec;
    logic [1:0]         w_need;
    logic               w_first;
    logic               w_active;
    logic [1:0]         w_coll;
    logic               w_done;
    logic               w_timeout;
    logic [WIDTH-1:0]   w_opa;
    logic [WIDTH-1:0]   w_opb;
    logic               w_mode;
    logic [3:0]         w_cmd;
    logic               w_cin;
    logic [0:0]         w_nstate;
    logic [c_CNT_W-1:0] w_ncnt;
    logic [1:0]         w_ncoll;

    // Operand requirement of the command presented on the bus; unknown codes need both.
    always_comb begin
        w_need_dec = 2'b11;
        if (mode) begin
            case (cmd)
                4'd4, 4'd5: w_need_dec = 2'b01;
                4'd6, 4'd7: w_need_dec = 2'b10;
                default:    w_need_dec = 2'b11;
            endcase
        end else begin
            case (cmd)
                4'd6, 4'd8, 4'd9:   w_need_dec = 2'b01;
                4'd7, 4'd10, 4'd11: w_need_dec = 2'b10;
                default:            w_need_dec = 2'b11;
            endcase
        end
    end

    // The first beat defines the command; later beats only contribute operands.
    assign w_first   = (r_state == c_IDLE) && (inp_valid != 2'b00);
    assign w_active  = w_first || (r_state == c_WAIT);
    assign w_need    = (r_state == c_IDLE) ? w_need_dec : r_need;
    assign w_coll    = ((r_state == c_WAIT) ? r_coll : 2'b00) | inp_valid;
    assign w_done    = w_active && ((w_coll & w_need) == w_need);
    // Completion on the last window cycle takes priority over timeout.
    assign w_timeout = (r_state == c_WAIT) && !w_done && (r_cnt == c_LAST);

    // Values as they stand after this cycle's beat, so an issue can use them directly.
    assign w_opa  = inp_valid[0] ? opa : r_opa;
    assign w_opb  = inp_valid[1] ? opb : r_opb;
    assign w_mode = w_first ? mode : r_mode;
    assign w_cmd  = w_first ? cmd  : r_cmd;
    assign w_cin  = w_first ? cin  : r_cin;

    // Next state, window counter and collected mask.
    always_comb begin
        w_nstate = r_state;
        w_ncnt   = r_cnt;
        w_ncoll  = r_coll;
        case (r_state)
            c_IDLE: begin
                if (w_first && !w_done) begin
                    w_nstate = c_WAIT;
                    w_ncnt   = c_ONE;
                    w_ncoll  = inp_valid;
                end
            end
            c_WAIT: begin
                if (w_done || w_timeout) begin
                    w_nstate = c_IDLE;
                    w_ncnt   = '0;
                    w_ncoll  = 2'b00;
                end else begin
                    w_ncnt  = r_cnt + c_ONE;
                    w_ncoll = w_coll;
                end
            end
            default: begin
                w_nstate = c_IDLE;
                w_ncnt   = '0;
                w_ncoll  = 2'b00;
            end
        endcase
    end

    // State, operand capture and issue registers; everything freezes while ce is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_IDLE;
            r_cnt       <= '0;
            r_coll      <= 2'b00;
            r_need      <= 2'b00;
            r_mode      <= 1'b0;
            r_cmd       <= 4'd0;
            r_cin       <= 1'b0;
            r_opa       <= '0;
            r_opb       <= '0;
            r_out_valid <= 1'b0;
            r_timeout   <= 1'b0;
            r_out_mode  <= 1'b0;
            r_out_cmd   <= 4'd0;
            r_out_cin   <= 1'b0;
            r_out_opa   <= '0;
            r_out_opb   <= '0;
        end else if (ce) begin
            r_state     <= w_nstate;
            r_cnt       <= w_ncnt;
            r_coll      <= w_ncoll;
            r_out_valid <= w_done;
            r_timeout   <= w_timeout;
            if (w_first) begin
                r_need <= w_need_dec;
                r_mode <= mode;
                r_cmd  <= cmd;
                r_cin  <= cin;
            end
            if (w_active && inp_valid[0]) r_opa <= opa;
            if (w_active && inp_valid[1]) r_opb <= opb;
            if (w_done) begin
                r_out_mode <= w_mode;
                r_out_cmd  <= w_cmd;
                r_out_cin  <= w_cin;
                // Operands the command does not use keep their previous value.
                if (w_need[0]) r_out_opa <= w_opa;
                if (w_need[1]) r_out_opb <= w_opb;
            end
        end else begin
            // Pulses must not reappear once ce returns.
            r_out_valid <= 1'b0;
            r_timeout   <= 1'b0;
        end
    end

    assign out_valid   = r_out_valid & ce;
    assign timeout_err = r_timeout & ce;
    assign out_mode    = r_out_mode;
    assign out_cmd     = r_out_cmd;
    assign out_cin     = r_out_cin;
    assign out_opa     = r_out_opa;
    assign out_opb     = r_out_opb;
    assign busy        = (r_state == c_WAIT);

endmodule
`default_nettype wire

// File: tb/tb_alu_operand_collector.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_alu_operand_collector
// Description : Directed self-checking bench for alu_operand_collector.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_operand_collector;

    logic       clk;
    logic       rst;
    logic       ce;
    logic       mode;
    logic [3:0] cmd;
    logic       cin;
    logic [1:0] inp_valid;
    logic [7:0] opa;
    logic [7:0] opb;
    logic       out_valid;
    logic       out_mode;
    logic [3:0] out_cmd;
    logic       out_cin;
    logic [7:0] out_opa;
    logic [7:0] out_opb;
    logic       timeout_err;
    logic       busy;

    int total = 0;
    int bad   = 0;
    int cnt_a;
    int cnt_b;

    alu_operand_collector #(.WIDTH(8), .TIMEOUT(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .ce          (ce),
        .mode        (mode),
        .cmd         (cmd),
        .cin         (cin),
        .inp_valid   (inp_valid),
        .opa         (opa),
        .opb         (opb),
        .out_valid   (out_valid),
        .out_mode    (out_mode),
        .out_cmd     (out_cmd),
        .out_cin     (out_cin),
        .out_opa     (out_opa),
        .out_opb     (out_opb),
        .timeout_err (timeout_err),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and sample 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic m, input logic [3:0] c, input logic ci,
                        input logic [1:0] v, input logic [7:0] a, input logic [7:0] b);
        mode = m; cmd = c; cin = ci; inp_valid = v; opa = a; opb = b;
    endtask

    initial begin
        rst = 1'b1; ce = 1'b1;
        beat(1'b0, 4'd0, 1'b0, 2'b00, 8'h00, 8'h00);
        tick(); tick();
        chk("rst_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_tmo", timeout_err, 0);
        chk("rst_data", {out_mode, out_cmd, out_cin, out_opa, out_opb}, 0);
        rst = 1'b0;
        tick();

        // 1: both operands in one beat
        beat(1'b1, 4'd0, 1'b0, 2'b11, 8'h12, 8'h34);
        tick();
        inp_valid = 2'b00;
        chk("t1_valid", out_valid, 1);
        chk("t1_opa", out_opa, 8'h12);
        chk("t1_opb", out_opb, 8'h34);
        chk("t1_cmd", out_cmd, 0);
        chk("t1_mode", out_mode, 1);
        chk("t1_busy", busy, 0);
        tick();
        chk("t1_pulse_end", out_valid, 0);

        // 2: split arrival, later mode/cmd/cin ignored
        beat(1'b1, 4'd0, 1'b1, 2'b01, 8'hA5, 8'h00);
        cnt_a = 0; cnt_b = 0;
        tick();
        beat(1'b0, 4'd3, 1'b0, 2'b00, 8'hFF, 8'h00);
        for (int i = 0; i < 4; i++) begin
            if (busy) cnt_a++;
            if (out_valid) cnt_b++;
            tick();
        end
        if (busy) cnt_a++;
        if (out_valid) cnt_b++;
        chk("t2_busy_cycles", cnt_a, 5);
        chk("t2_no_early_valid", cnt_b, 0);
        beat(1'b0, 4'd3, 1'b0, 2'b10, 8'hFF, 8'h5A);
        tick();
        inp_valid = 2'b00;
        chk("t2_valid", out_valid, 1);
        chk("t2_opa", out_opa, 8'hA5);
        chk("t2_opb", out_opb, 8'h5A);
        chk("t2_cmd_mode_cin", {out_mode, out_cmd, out_cin}, {1'b1, 4'd0, 1'b1});
        chk("t2_busy", busy, 0);

        // 3: timeout after 16 cycles
        beat(1'b0, 4'd0, 1'b0, 2'b01, 8'h3C, 8'h00);
        tick();
        inp_valid = 2'b00;
        cnt_a = 0; cnt_b = 0;
        for (int i = 0; i < 14; i++) begin
            tick();
            if (timeout_err) cnt_a++;
            if (out_valid) cnt_b++;
        end
        chk("t3_no_early_tmo", cnt_a, 0);
        tick();
        chk("t3_tmo", timeout_err, 1);
        chk("t3_no_valid", out_valid | cnt_b[0], 0);
        chk("t3_busy", busy, 0);
        chk("t3_opa_held", out_opa, 8'hA5);
        tick();
        chk("t3_tmo_end", timeout_err, 0);

        // 3b: completion on the final window cycle
        beat(1'b0, 4'd0, 1'b0, 2'b01, 8'h11, 8'h00);
        tick();
        inp_valid = 2'b00;
        for (int i = 0; i < 14; i++) tick();
        chk("t3b_busy", busy, 1);
        beat(1'b0, 4'd0, 1'b0, 2'b10, 8'h00, 8'h22);
        tick();
        inp_valid = 2'b00;
        chk("t3b_valid", out_valid, 1);
        chk("t3b_tmo", timeout_err, 0);
        chk("t3b_ops", {out_opa, out_opb}, 16'h1122);
        chk("t3b_mode", out_mode, 0);

        // 4: single operand INC_B, unused opa stays stale
        beat(1'b1, 4'd6, 1'b0, 2'b10, 8'h77, 8'hFF);
        tick();
        inp_valid = 2'b00;
        chk("t4_valid", out_valid, 1);
        chk("t4_busy", busy, 0);
        chk("t4_opb", out_opb, 8'hFF);
        chk("t4_opa_stale", out_opa, 8'h11);
        chk("t4_cmd", out_cmd, 6);
        // INC_A with only opb supplied waits for opa
        beat(1'b1, 4'd4, 1'b0, 2'b10, 8'h00, 8'h99);
        tick();
        inp_valid = 2'b00;
        chk("t4b_busy", busy, 1);
        chk("t4b_no_valid", out_valid, 0);
        tick();
        chk("t4b_busy2", busy, 1);
        beat(1'b1, 4'd4, 1'b0, 2'b01, 8'h44, 8'h00);
        tick();
        chk("t4b_valid", out_valid, 1);
        chk("t4b_opa", out_opa, 8'h44);
        chk("t4b_opb_stale", out_opb, 8'hFF);
        chk("t4b_cmd", out_cmd, 4);
        // back-to-back: new first beat while out_valid is high
        beat(1'b1, 4'd1, 1'b0, 2'b11, 8'h01, 8'h02);
        tick();
        inp_valid = 2'b00;
        chk("b2b_valid", out_valid, 1);
        chk("b2b_ops", {out_opa, out_opb, out_cmd}, {8'h01, 8'h02, 4'd1});
        tick();

        // 5: ce gating in WAIT with counter=3
        beat(1'b1, 4'd0, 1'b0, 2'b01, 8'hAA, 8'h00);
        tick();
        inp_valid = 2'b00;
        tick(); tick();
        ce = 1'b0;
        beat(1'b1, 4'd0, 1'b0, 2'b10, 8'h00, 8'hEE);
        cnt_a = 0; cnt_b = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (busy) cnt_a++;
            if (timeout_err || out_valid) cnt_b++;
        end
        chk("t5_busy_held", cnt_a, 20);
        chk("t5_no_pulse", cnt_b, 0);
        ce = 1'b1;
        beat(1'b1, 4'd0, 1'b0, 2'b10, 8'h00, 8'hBB);
        tick();
        inp_valid = 2'b00;
        chk("t5_valid", out_valid, 1);
        chk("t5_ops", {out_opa, out_opb}, 16'hAABB);
        tick();

        // 6: async reset mid-WAIT
        beat(1'b1, 4'd0, 1'b0, 2'b01, 8'h05, 8'h00);
        tick();
        inp_valid = 2'b00;
        chk("t6_busy_pre", busy, 1);
        #2 rst = 1'b1;
        #1;
        chk("t6_busy_rst", busy, 0);
        chk("t6_data_rst", {out_valid, timeout_err, out_mode, out_cmd, out_cin, out_opa, out_opb}, 0);
        @(posedge clk);
        #2 rst = 1'b0;
        beat(1'b1, 4'd2, 1'b0, 2'b11, 8'h66, 8'h77);
        tick();
        inp_valid = 2'b00;
        chk("t6_valid", out_valid, 1);
        chk("t6_ops", {out_opa, out_opb, out_cmd}, {8'h66, 8'h77, 4'd2});
        cnt_a = 0;
        for (int i = 0; i < 20; i++) begin
            if (timeout_err) cnt_a++;
            tick();
        end
        chk("t6_no_tmo", cnt_a, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard stop in case the sequence stalls.
    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/alu_operand_collector.md
Name: alu_operand_collector

Overview:
- Front-end stage that sits directly upstream of the ALU core, on the operand/command bus the ALU bench drives (ce, mode, cmd, cin, inp_valid, opa, opb).
- Operands for a single operation may arrive on different cycles. The block accumulates them, applies a 16-cycle arrival window, and presents one complete, aligned operation to the ALU core as a single-cycle valid pulse.
- Flags a timeout when the window expires before the required operands have arrived.

Parameters:
WIDTH, 8, operand width; matches the codebase WIDTH define.
TIMEOUT, 16, max cycles from first operand beat to completion.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-high
ce  input  1  clock enable; when 0 the block freezes
mode  input  1  1 = arithmetic, 0 = logical
cmd  input  4  operation code
cin  input  1  carry in
inp_valid  input  2  bit0 = opa valid, bit1 = opb valid
opa  input  WIDTH  operand A
opb  input  WIDTH  operand B
out_valid  output  1  one-cycle pulse, complete operation presented
out_mode  output  1  latched mode
out_cmd  output  4  latched cmd
out_cin  output  1  latched cin
out_opa  output  WIDTH  latched operand A
out_opb  output  WIDTH  latched operand B
timeout_err  output  1  one-cycle pulse, window expired
busy  output  1  high while in WAIT

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- Reset: state=IDLE, counter=0, collected mask=00. All outputs, including all out_* data, are 0.
- ce=0: inputs ignored, state, counter and registers held, out_valid and timeout_err forced 0 that cycle.
- Operand requirement mask "need", decoded from mode/cmd at the first beat:
  - mode=1, cmd 4,5 (INC_A, DEC_A): need=01.
  - mode=1, cmd 6,7 (INC_B, DEC_B): need=10.
  - mode=0, cmd 6,8,9 (NOT_A, SHR1_A, SHL1_A): need=01.
  - mode=0, cmd 7,10,11 (NOT_B, SHR1_B, SHL1_B): need=10.
  - All other codes, including illegal ones: need=11. Illegal codes are forwarded unchanged; the ALU core flags err.
- States are IDLE and WAIT.
- IDLE, ce=1, inp_valid!=00 (first beat):
  - Latch mode, cmd and cin.
  - Latch opa if bit0 is set and opb if bit1 is set; collected=inp_valid.
  - If collected covers need: issue and stay in IDLE.
  - Otherwise: go to WAIT with counter=1.
- IDLE, inp_valid=00: no action.
- WAIT, ce=1:
  - mode, cmd and cin inputs are ignored; the first-beat values are kept.
  - Each valid bit latches its operand (a repeat overwrites the earlier value) and ORs into collected.
  - If collected covers need: issue, go to IDLE, counter=0.
  - Else if counter==TIMEOUT-1: pulse timeout_err next cycle, go to IDLE, clear collected; out_* data registers hold their last issued values.
  - Else: counter+1.
- Completion on the final window cycle (counter==TIMEOUT-1) wins over timeout.
- Issue:
  - out_valid=1 on the cycle after the completing edge; latency is 1 cycle from the completing beat.
  - out_* registers update at the same edge and hold until the next issue.
  - Operand registers not required by need keep their stale value.
- A first beat presented in the same cycle out_valid is high is accepted normally, giving back-to-back throughput of 1 operation per cycle.
- busy=1 exactly while state==WAIT.
- Reset asserted mid-WAIT: immediate return to IDLE and all outputs zero; the partial operation is discarded with no timeout_err.

Test Plan:
1. Two-operand same cycle: mode=1, cmd=0, opa=8'h12, opb=8'h34, inp_valid=11 -> next cycle out_valid=1, out_opa=12, out_opb=34, out_cmd=0, busy never high.
2. Split arrival: mode=1, cmd=0, inp_valid=01, opa=8'hA5; opb=8'h5A with inp_valid=10 five cycles later -> busy high for 5 cycles, out_valid one cycle after the opb beat, out_opa=A5, out_opb=5A.
3. Timeout: mode=0, cmd=0, inp_valid=01 only, then 15 cycles of 00 -> timeout_err pulses 16 cycles after the first beat, out_valid stays 0. An opb beat on the 16th cycle of a repeat run -> out_valid instead of timeout_err.
4. Single-operand: mode=1, cmd=6 (INC_B), inp_valid=10, opb=8'hFF -> out_valid next cycle with no WAIT. mode=1, cmd=4 with inp_valid=10 -> enters WAIT until an opa beat arrives.
5. ce gating: in WAIT with counter=3, hold ce=0 for 20 cycles -> no timeout, busy held. Restoring ce with an opb beat -> out_valid.
6. Async reset: assert rst mid-WAIT between clock edges -> busy and all outputs 0 immediately. A new inp_valid=11 beat after release -> normal issue, no timeout_err.
